// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Captures a byte plus its parity config, pulses DATA_VALID, then holds everything until TX BUSY falls.
module uart_tx_arbiter #(
    parameter int unsigned  NUM_REQ      = 4,
    parameter int unsigned  DATA_WIDTH   = 8,
    parameter int unsigned  BUSY_TIMEOUT = 4,
    localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned TO_W         = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ARB_EN,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
    input  logic [NUM_REQ-1:0]            REQ_PAR_TYPE,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    input  logic                          TX_BUSY,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_DATA_VALID,
    output logic                          TX_PAR_EN,
    output logic                          TX_PAR_TYPE,
    output logic [ID_W-1:0]               GRANT_ID,
    output logic                          ARB_BUSY,
    output logic                          TIMEOUT_ERR,
    input  logic                          ERR_CLR
);

    localparam logic [ID_W-1:0] PTR_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [TO_W-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_par_en_q, tx_par_en_d;
    logic                    tx_par_type_q, tx_par_type_d;
    logic                    tx_dv_q, tx_dv_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    err_q, err_d;

    logic                    found_hi, found_lo, win_found;
    logic [ID_W-1:0]         idx_hi, idx_lo, win_idx;
    logic [NUM_REQ-1:0]      win_oh;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    win_par_en, win_par_type;

    // Round-robin pick: first valid index above ptr, otherwise first valid at or below it (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (REQ_VALID[i]) begin
                if (ID_W'(i) > ptr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = ID_W'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = ID_W'(i);
                end
            end
        end
        win_found = found_hi | found_lo;
        win_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Winner's payload and one-hot acknowledge.
    always_comb begin
        win_oh       = '0;
        win_data     = '0;
        win_par_en   = 1'b0;
        win_par_type = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == win_idx) begin
                win_oh[i]    = 1'b1;
                win_data     = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                win_par_en   = REQ_PAR_EN[i];
                win_par_type = REQ_PAR_TYPE[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_par_en_d   = tx_par_en_q;
        tx_par_type_d = tx_par_type_q;
        tx_dv_d       = 1'b0;
        req_ack_d     = '0;
        grant_d       = grant_q;
        err_d         = ERR_CLR ? 1'b0 : err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ARB_EN && !TX_BUSY && win_found) begin
                    tx_data_d     = win_data;
                    tx_par_en_d   = win_par_en;
                    tx_par_type_d = win_par_type;
                    grant_d       = win_idx;
                    ptr_d         = win_idx;
                    tx_dv_d       = 1'b1;
                    req_ack_d     = win_oh;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Set beats a same-cycle clear so a timeout is never lost.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            ptr_q         <= PTR_RST;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            tx_par_en_q   <= 1'b0;
            tx_par_type_q <= 1'b0;
            tx_dv_q       <= 1'b0;
            req_ack_q     <= '0;
            grant_q       <= '0;
            arb_busy_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_type_q <= tx_par_type_d;
            tx_dv_q       <= tx_dv_d;
            req_ack_q     <= req_ack_d;
            grant_q       <= grant_d;
            arb_busy_q    <= arb_busy_d;
            err_q         <= err_d;
        end
    end

    assign TX_P_DATA     = tx_data_q;
    assign TX_PAR_EN     = tx_par_en_q;
    assign TX_PAR_TYPE   = tx_par_type_q;
    assign TX_DATA_VALID = tx_dv_q;
    assign REQ_ACK       = req_ack_q;
    assign GRANT_ID      = grant_q;
    assign ARB_BUSY      = arb_busy_q;
    assign TIMEOUT_ERR   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin reference model and a simple transmitter BUSY model.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic              CLK, RST, ARB_EN, TX_BUSY, ERR_CLR;
    logic [N-1:0]      REQ_VALID, REQ_PAR_EN, REQ_PAR_TYPE, REQ_ACK;
    logic [N*DW-1:0]   REQ_DATA;
    logic [DW-1:0]     TX_P_DATA;
    logic              TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYPE, ARB_BUSY, TIMEOUT_ERR;
    logic [1:0]        GRANT_ID;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BUSY_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .ARB_EN(ARB_EN),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_PAR_EN(REQ_PAR_EN), .REQ_PAR_TYPE(REQ_PAR_TYPE), .REQ_ACK(REQ_ACK),
        .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
        .TX_PAR_EN(TX_PAR_EN), .TX_PAR_TYPE(TX_PAR_TYPE), .GRANT_ID(GRANT_ID),
        .ARB_BUSY(ARB_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Transmitter model: 0 = BUSY rises the cycle after DATA_VALID, 1 = stuck low, 2 = stuck high.
    int   tx_mode = 0;
    int   busy_len = 11;
    int   busy_left = 0;
    logic dv_seen, rst_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic check_zero(input string p);
        check({p, "_dv"},    32'(TX_DATA_VALID), 32'd0);
        check({p, "_ack"},   32'(REQ_ACK),       32'd0);
        check({p, "_data"},  32'(TX_P_DATA),     32'd0);
        check({p, "_pe"},    32'(TX_PAR_EN),     32'd0);
        check({p, "_pt"},    32'(TX_PAR_TYPE),   32'd0);
        check({p, "_gid"},   32'(GRANT_ID),      32'd0);
        check({p, "_busy"},  32'(ARB_BUSY),      32'd0);
        check({p, "_err"},   32'(TIMEOUT_ERR),   32'd0);
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1; ERR_CLR = 1'b0; ARB_EN = 1'b1; tx_mode = 0;
        REQ_VALID = '0; REQ_PAR_EN = '0; REQ_PAR_TYPE = '0; REQ_DATA = '0;
        smp();
        tick();
        RST = 1'b0;
        smp();
    endtask

    task automatic wait_dv(input string tag, input int bound);
        for (int c = 0; c < bound; c++) begin
            if (TX_DATA_VALID === 1'b1) return;
            tick();
            smp();
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound, output int n);
        n = 0;
        while (ARB_BUSY !== 1'b0 && n < bound) begin
            tick();
            smp();
            n++;
        end
        check(tag, 32'(ARB_BUSY), 32'd0);
    endtask

    initial begin : tx_model
        TX_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            dv_seen  = TX_DATA_VALID;
            rst_seen = RST;
            @(posedge CLK);
            #2;
            if (rst_seen === 1'b1)     busy_left = 0;
            else if (dv_seen === 1'b1) busy_left = (busy_len == 0) ? int'($urandom_range(6, 1)) : busy_len;
            else if (busy_left > 0)    busy_left--;
            case (tx_mode)
                1:       TX_BUSY = 1'b0;
                2:       TX_BUSY = 1'b1;
                default: TX_BUSY = (busy_left != 0);
            endcase
        end
    end

    // Reference: every issue must pick the next valid requester after the last winner,
    // carry that requester's byte/config, and hold it on the outputs until the next issue.
    logic [N-1:0]    p_valid, p_pe, p_pt;
    logic [N*DW-1:0] p_data;
    logic            p_dv;
    int              mptr, e_gid;
    logic [DW-1:0]   e_data;
    logic            e_pe, e_pt;

    initial begin : scoreboard
        int w;
        int idx;
        mptr = N - 1; e_gid = 0; e_data = '0; e_pe = 1'b0; e_pt = 1'b0;
        p_valid = '0; p_pe = '0; p_pt = '0; p_data = '0; p_dv = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_DATA_VALID === 1'b1) begin
                check("sb_consecutive_dv", 32'(p_dv), 32'd0);
                w = -1;
                for (int k = 1; k <= int'(N); k++) begin
                    idx = (mptr + k) % int'(N);
                    if (w < 0 && ((p_valid >> idx) & 4'b1) != 4'b0) w = idx;
                end
                check("sb_grant_exists", 32'(w >= 0), 32'd1);
                if (w >= 0) begin
                    mptr   = w;
                    e_gid  = w;
                    e_data = DW'(p_data >> (w * int'(DW)));
                    e_pe   = 1'((p_pe >> w) & 4'b1);
                    e_pt   = 1'((p_pt >> w) & 4'b1);
                end
            end
            check("sb_ack",  32'(REQ_ACK), (TX_DATA_VALID === 1'b1) ? (32'd1 << e_gid) : 32'd0);
            check("sb_data", 32'(TX_P_DATA),   32'(e_data));
            check("sb_pe",   32'(TX_PAR_EN),   32'(e_pe));
            check("sb_pt",   32'(TX_PAR_TYPE), 32'(e_pt));
            check("sb_gid",  32'(GRANT_ID),    32'(e_gid));
            if (RST === 1'b1) begin
                mptr = N - 1; e_gid = 0; e_data = '0; e_pe = 1'b0; e_pt = 1'b0;
            end
            p_valid = REQ_VALID; p_pe = REQ_PAR_EN; p_pt = REQ_PAR_TYPE; p_data = REQ_DATA;
            p_dv    = (RST === 1'b1) ? 1'b0 : TX_DATA_VALID;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, last_dv, dv_cnt, n_raise, n_ack;
        logic [N-1:0] ack_seen;

        RST = 1'b1; ARB_EN = 1'b0; ERR_CLR = 1'b0;
        REQ_VALID = '0; REQ_DATA = '0; REQ_PAR_EN = '0; REQ_PAR_TYPE = '0;
        tick(); tick(); smp();
        check_zero("rst");

        // 1: single request, 11-cycle frame
        busy_len = 11;
        do_reset();
        tick();
        REQ_VALID = 4'b0100; REQ_DATA = 32'h00A5_0000; REQ_PAR_EN = 4'b0100; REQ_PAR_TYPE = 4'b0100;
        smp();
        check("t1_dv_early", 32'(TX_DATA_VALID), 32'd0);
        tick(); smp();
        check("t1_dv",   32'(TX_DATA_VALID), 32'd1);
        check("t1_ack",  32'(REQ_ACK),       32'h4);
        check("t1_data", 32'(TX_P_DATA),     32'hA5);
        check("t1_pe",   32'(TX_PAR_EN),     32'd1);
        check("t1_pt",   32'(TX_PAR_TYPE),   32'd1);
        check("t1_gid",  32'(GRANT_ID),      32'd2);
        tick();
        REQ_VALID = '0; REQ_DATA = '0; REQ_PAR_EN = '0; REQ_PAR_TYPE = '0;
        smp();
        check("t1_dv_pulse", 32'(TX_DATA_VALID), 32'd0);
        check("t1_ack_pulse", 32'(REQ_ACK), 32'd0);
        check("t1_data_hold", 32'(TX_P_DATA), 32'hA5);
        wait_idle("t1_idle", 40, n);
        check("t1_frame_len", 32'(n), 32'd12);

        // 2: all requesters continuously valid, grant order 0,1,2,3,0
        busy_len = 3;
        do_reset();
        tick();
        REQ_VALID = 4'hF; REQ_DATA = 32'h1312_1110; REQ_PAR_EN = 4'b1010; REQ_PAR_TYPE = 4'b0110;
        smp();
        last_dv = 0;
        for (int g = 0; g < 5; g++) begin
            wait_dv("t2_wait_dv", 20);
            check("t2_gid",  32'(GRANT_ID),  32'(g % 4));
            check("t2_ack",  32'(REQ_ACK),   32'd1 << (g % 4));
            check("t2_data", 32'(TX_P_DATA), 32'(16 + g % 4));
            if (g > 0) check("t2_interval", 32'(cyc - last_dv), 32'(busy_len + 3));
            last_dv = cyc;
            tick(); smp();
        end
        tick(); REQ_VALID = '0; smp();
        wait_idle("t2_idle", 20, n);

        // 3: BUSY never rises -> timeout; clear; clear coincident with a new timeout
        do_reset();
        tick();
        tx_mode = 1; REQ_VALID = 4'b1000; REQ_DATA = 32'h5A00_0000;
        smp();
        check("t3_dv_early", 32'(TX_DATA_VALID), 32'd0);
        tick(); smp();
        check("t3_dv",  32'(TX_DATA_VALID), 32'd1);
        check("t3_gid", 32'(GRANT_ID),      32'd3);
        tick(); REQ_VALID = '0; smp();
        for (int c = 0; c < 3; c++) begin tick(); smp(); end
        check("t3_err_not_yet",  32'(TIMEOUT_ERR), 32'd0);
        check("t3_busy_not_yet", 32'(ARB_BUSY),    32'd1);
        tick(); smp();
        check("t3_err_set",   32'(TIMEOUT_ERR), 32'd1);
        check("t3_back_idle", 32'(ARB_BUSY),    32'd0);
        tick();
        tx_mode = 0; REQ_VALID = 4'b0001; REQ_DATA = 32'h0000_0033;
        smp();
        tick(); smp();
        check("t3_next_dv",  32'(TX_DATA_VALID), 32'd1);
        check("t3_next_gid", 32'(GRANT_ID),      32'd0);
        check("t3_err_kept", 32'(TIMEOUT_ERR),   32'd1);
        tick(); REQ_VALID = '0; smp();
        wait_idle("t3_idle", 20, n);
        tick(); ERR_CLR = 1'b1; smp();
        check("t3_err_before_clr", 32'(TIMEOUT_ERR), 32'd1);
        tick(); ERR_CLR = 1'b0; smp();
        check("t3_err_cleared", 32'(TIMEOUT_ERR), 32'd0);
        tick(); tx_mode = 1; REQ_VALID = 4'b0010; smp();
        tick(); smp();
        check("t3_dv2", 32'(TX_DATA_VALID), 32'd1);
        tick(); REQ_VALID = '0; smp();
        tick(); smp();
        tick(); smp();
        tick(); ERR_CLR = 1'b1; smp();
        tick(); ERR_CLR = 1'b0; smp();
        check("t3_set_beats_clr", 32'(TIMEOUT_ERR), 32'd1);
        check("t3_idle2",         32'(ARB_BUSY),    32'd0);
        tx_mode = 0;

        // 4: reset during WAIT_DONE, pointer returns to requester 0 priority
        busy_len = 11;
        do_reset();
        tick(); REQ_VALID = 4'b0100; REQ_DATA = 32'h0077_0000; smp();
        tick(); smp();
        check("t4_gid_first", 32'(GRANT_ID), 32'd2);
        tick(); REQ_VALID = '0; smp();
        tick(); smp();
        tick(); smp();
        check("t4_in_frame", 32'(ARB_BUSY), 32'd1);
        tick();
        RST = 1'b1; REQ_VALID = 4'b1001; REQ_DATA = 32'hC300_00E1; REQ_PAR_EN = 4'b0001; REQ_PAR_TYPE = 4'b0001;
        smp();
        tick(); RST = 1'b0; smp();
        check_zero("t4");
        tick(); smp();
        check("t4_dv",   32'(TX_DATA_VALID), 32'd1);
        check("t4_gid",  32'(GRANT_ID),      32'd0);
        check("t4_ack",  32'(REQ_ACK),       32'h1);
        check("t4_data", 32'(TX_P_DATA),     32'hE1);
        check("t4_pe",   32'(TX_PAR_EN),     32'd1);
        check("t4_pt",   32'(TX_PAR_TYPE),   32'd1);
        tick(); REQ_VALID = '0; smp();
        wait_idle("t4_idle", 30, n);

        // 5: ARB_EN dropped mid-frame with requests pending
        busy_len = 5;
        do_reset();
        tick(); REQ_VALID = 4'hF; REQ_DATA = 32'h4433_2211; REQ_PAR_EN = 4'b0101; REQ_PAR_TYPE = 4'b0011; smp();
        wait_dv("t5_wait_dv", 10);
        check("t5_gid0", 32'(GRANT_ID), 32'd0);
        tick(); smp();
        tick(); smp();
        tick(); ARB_EN = 1'b0; smp();
        dv_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick(); smp();
            if (TX_DATA_VALID === 1'b1) dv_cnt++;
        end
        check("t5_no_issue",  32'(dv_cnt),   32'd0);
        check("t5_finished",  32'(ARB_BUSY), 32'd0);
        tick(); ARB_EN = 1'b1; smp();
        check("t5_dv_early", 32'(TX_DATA_VALID), 32'd0);
        tick(); smp();
        check("t5_resume_dv",   32'(TX_DATA_VALID), 32'd1);
        check("t5_resume_gid",  32'(GRANT_ID),      32'd1);
        check("t5_resume_data", 32'(TX_P_DATA),     32'h22);
        tick(); REQ_VALID = '0; smp();
        wait_idle("t5_idle", 30, n);

        // 6: foreign BUSY in IDLE blocks grants
        busy_len = 3;
        do_reset();
        tick(); tx_mode = 2; smp();
        tick(); REQ_VALID = 4'b0010; REQ_DATA = 32'h0000_9900; smp();
        for (int c = 0; c < 5; c++) begin
            check("t6_no_dv",   32'(TX_DATA_VALID), 32'd0);
            check("t6_no_ack",  32'(REQ_ACK),       32'd0);
            check("t6_idle",    32'(ARB_BUSY),      32'd0);
            tick(); smp();
        end
        tick(); tx_mode = 0; smp();
        check("t6_dv_early", 32'(TX_DATA_VALID), 32'd0);
        tick(); smp();
        check("t6_dv",   32'(TX_DATA_VALID), 32'd1);
        check("t6_gid",  32'(GRANT_ID),      32'd1);
        check("t6_ack",  32'(REQ_ACK),       32'h2);
        check("t6_data", 32'(TX_P_DATA),     32'h99);
        tick(); REQ_VALID = '0; smp();
        wait_idle("t6_idle", 20, n);

        // Random traffic: requesters raise with random payloads, drop/update after ack
        busy_len = 0;
        do_reset();
        ack_seen = '0; n_raise = 0; n_ack = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            ARB_EN = (c >= 500) ? 1'b1 : ($urandom_range(9, 0) != 0);
            for (int i = 0; i < int'(N); i++) begin
                if (ack_seen[i]) REQ_VALID[i] = 1'b0;
                if (!REQ_VALID[i] && c < 500 && $urandom_range(2, 0) == 0) begin
                    REQ_VALID[i]        = 1'b1;
                    REQ_DATA[i*DW +: DW] = DW'($urandom);
                    REQ_PAR_EN[i]       = 1'($urandom_range(1, 0));
                    REQ_PAR_TYPE[i]     = 1'($urandom_range(1, 0));
                    n_raise++;
                end
            end
            smp();
            ack_seen = REQ_ACK;
            n_ack += $countones(REQ_ACK);
        end
        tick(); REQ_VALID = REQ_VALID & ~ack_seen; smp();
        check("rand_drained",   32'(REQ_VALID),   32'd0);
        check("rand_ack_count", 32'(n_ack),       32'(n_raise));
        check("rand_no_err",    32'(TIMEOUT_ERR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters. It captures one byte plus that requester's parity configuration, then issues a single-cycle DATA_VALID to the transmitter. It tracks the transmitter's BUSY to detect frame start and end, and holds data and configuration stable for the whole frame. It sits between the requesting blocks and the UART TX top, driving its P_DATA, DATA_VALID, PAR_EN and PAR_TYPE inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, byte width, matches the transmitter data width
BUSY_TIMEOUT, 4, max cycles to wait after DATA_VALID for TX BUSY to rise
Derived: ID_W = max(1, ceil(log2(NUM_REQ))); TO_W = ceil(log2(BUSY_TIMEOUT+1))

Ports:
CLK  in  1  clock; one clock domain
RST  in  1  reset; synchronous, active-high
ARB_EN  in  1  1 = new grants allowed; 0 = finish current frame, then hold in IDLE
REQ_VALID  in  NUM_REQ  per-requester request; held until REQ_ACK
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
REQ_PAR_TYPE  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
REQ_ACK  out  NUM_REQ  one-hot, one-cycle pulse: byte i captured
TX_BUSY  in  1  BUSY from the UART transmitter
TX_P_DATA  out  DATA_WIDTH  byte to the transmitter, registered
TX_DATA_VALID  out  1  one-cycle issue pulse to the transmitter
TX_PAR_EN  out  1  parity enable for the current frame, registered
TX_PAR_TYPE  out  1  parity type for the current frame, registered
GRANT_ID  out  ID_W  index of the requester that owns the current or last frame
ARB_BUSY  out  1  1 in any state other than IDLE
TIMEOUT_ERR  out  1  sticky: TX_BUSY never rose after an issue
ERR_CLR  in  1  clears TIMEOUT_ERR (one-cycle pulse)

Behaviour:
- Reset, synchronous on RST=1 at a CLK edge, effective from any state:
  - All outputs go to 0. State goes to IDLE.
  - RR pointer goes to NUM_REQ-1, so requester 0 has priority first.
  - The timeout counter goes to 0.
  - A reset mid-frame drops the frame. No REQ_ACK is re-issued. The transmitter is reset by the same RST.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - A grant is made when ARB_EN=1, TX_BUSY=0 and |REQ_VALID.
  - Winner = first i with REQ_VALID[i]=1, searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - At the edge: latch REQ_DATA[i], REQ_PAR_EN[i] and REQ_PAR_TYPE[i] into the TX_* registers; GRANT_ID<=i; ptr<=i; go to ISSUE.
  - No grant: stay in IDLE. TX_* data and config registers hold their last values.
- ISSUE (exactly 1 cycle): TX_DATA_VALID=1 and REQ_ACK[GRANT_ID]=1; next state WAIT_BUSY with counter cleared.
- Latency: REQ_VALID sampled in cycle t gives TX_DATA_VALID and REQ_ACK in cycle t+1.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Otherwise the counter increments. If counter==BUSY_TIMEOUT-1 and TX_BUSY=0: set TIMEOUT_ERR and go to IDLE.
- WAIT_DONE: stay while TX_BUSY=1. On TX_BUSY=0, go to IDLE.
- Back-to-back: a new grant is possible in the first IDLE cycle, giving a minimum 1-cycle gap from BUSY fall to the next ISSUE.
- TX_P_DATA, TX_PAR_EN and TX_PAR_TYPE are constant from ISSUE through WAIT_DONE. The transmitter's FSM and parity logic rely on this.
- The requester must hold REQ_VALID and REQ_DATA until it sees REQ_ACK, and must drop or update them in the cycle after REQ_ACK. The arbiter only samples in IDLE, so no double capture is possible.
- REQ_VALID deasserting before a grant: the request is withdrawn and is not remembered.
- ARB_EN=0 mid-frame: the frame completes normally, then the arbiter stays in IDLE.
- TX_BUSY=1 while in IDLE (foreign or leftover frame): no grant until it falls.
- Simultaneous ERR_CLR and timeout in the same cycle: the set wins.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 frames.
- ARB_BUSY = (state != IDLE).

Test Plan:
1. Reset, then only REQ_VALID[2]=1 with data 0xA5, PAR_EN=1, PAR_TYPE=1; model BUSY rising 1 cycle after DATA_VALID for 11 cycles -> TX_DATA_VALID is a 1-cycle pulse the cycle after request; TX_P_DATA=0xA5, TX_PAR_EN=1, TX_PAR_TYPE=1 held until BUSY falls; REQ_ACK=4'b0100 coincides with TX_DATA_VALID; GRANT_ID=2.
2. All four requesters valid continuously with bytes 0x10..0x13 -> grant order 0,1,2,3,0 with 1-cycle IDLE gap after each BUSY fall; each REQ_ACK is one-hot.
3. TX_BUSY tied 0, one request -> after ISSUE plus BUSY_TIMEOUT=4 cycles: TIMEOUT_ERR=1 and back in IDLE; the next request is still served; ERR_CLR pulse clears the flag; ERR_CLR coincident with a second timeout leaves the flag at 1.
4. RST=1 asserted during WAIT_DONE -> next cycle all outputs 0, IDLE, and the next grant goes to requester 0 even though ptr had been 2.
5. ARB_EN dropped during WAIT_DONE with requests pending -> current frame finishes, no further TX_DATA_VALID; re-enabling resumes from ptr+1.
6. TX_BUSY held 1 externally in IDLE with REQ_VALID[1]=1 -> no grant and no REQ_ACK until TX_BUSY=0; then grant to requester 1 the following cycle.
